// File: rtl/seq_bit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_bit_serializer_if
// Purpose  : Word handshake and serial-stream bundle for seq_bit_serializer.
// Revision : 1.0  initial release
// ============================================================================
interface seq_bit_serializer_if #(
   parameter int WIDTH = 12
) ();

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             ser_en;
   logic             ser_out;
   logic             ser_valid;
   logic             frame_start;
   logic             frame_end;
   logic             busy;

   // Upstream word source plus downstream bit consumer
   modport master (
      output in_data,
      output in_valid,
      output ser_en,
      input  in_ready,
      input  ser_out,
      input  ser_valid,
      input  frame_start,
      input  frame_end,
      input  busy
   );

   // The serializer itself
   modport slave (
      input  in_data,
      input  in_valid,
      input  ser_en,
      output in_ready,
      output ser_out,
      output ser_valid,
      output frame_start,
      output frame_end,
      output busy
   );

endinterface
`default_nettype wire

// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : seq_bit_serializer
// Purpose  : Parallel-to-serial feeder with a one-word holding buffer and
//            frame markers; optional even-parity bit under SER_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module seq_bit_serializer #(
   parameter int   WIDTH      = 12,
   parameter bit   LSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  wire logic            clk,
   input  wire logic            rst,
   seq_bit_serializer_if.slave  sif
);

`ifdef SER_PARITY_EN
   localparam int c_frame_len = WIDTH + 1;
`else
   localparam int c_frame_len = WIDTH;
`endif
   localparam int                c_cnt_w    = $clog2(WIDTH + 2);
   localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_frame_len - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t                  r_state;
   logic                    r_hold_full;
   logic [WIDTH-1:0]        r_hold_data;
   logic [c_frame_len-1:0]  r_shift;
   logic [c_cnt_w-1:0]      r_count;
   logic                    r_ser_out;
   logic                    r_ser_valid;
   logic                    r_frame_start;
   logic                    r_frame_end;
   logic                    r_busy;

   logic [c_frame_len-1:0]  w_frame_word;
   logic                    w_accept;
   logic                    w_advance;
   logic                    w_last;
   logic                    w_load;
   state_t                  w_state_nxt;
   logic [c_frame_len-1:0]  w_shift_nxt;
   logic [c_cnt_w-1:0]      w_count_nxt;
   logic                    w_hold_full_nxt;
   logic                    w_shifting_nxt;

   // Frame is pre-ordered so the next bit to send always sits at bit 0
   always_comb begin
      w_frame_word = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_frame_word[i] = LSB_FIRST ? r_hold_data[i] : r_hold_data[WIDTH-1-i];
      end
`ifdef SER_PARITY_EN
      w_frame_word[WIDTH] = ^r_hold_data;
`endif
   end

   assign w_accept  = sif.in_valid & ~r_hold_full;
   assign w_advance = (r_state == S_SHIFT) & sif.ser_en;
   assign w_last    = (r_count == c_last_idx);
   // Reload on the last advance keeps back-to-back frames gapless
   assign w_load    = r_hold_full & ((r_state == S_IDLE) | (w_advance & w_last));

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_count_nxt = r_count;
      if (w_load) begin
         w_state_nxt = S_SHIFT;
         w_shift_nxt = w_frame_word;
         w_count_nxt = '0;
      end else if (w_advance) begin
         if (w_last) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
         end else begin
            w_shift_nxt = r_shift >> 1;
            w_count_nxt = r_count + c_cnt_one;
         end
      end
      w_hold_full_nxt = w_load ? 1'b0 : (w_accept ? 1'b1 : r_hold_full);
      w_shifting_nxt  = (w_state_nxt == S_SHIFT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_hold_full   <= 1'b0;
         r_hold_data   <= '0;
         r_shift       <= '0;
         r_count       <= '0;
         r_ser_out     <= IDLE_LEVEL;
         r_ser_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_shift     <= w_shift_nxt;
         r_count     <= w_count_nxt;
         if (w_accept) begin
            r_hold_data <= sif.in_data;
         end
         r_ser_valid   <= w_shifting_nxt;
         r_ser_out     <= w_shifting_nxt ? w_shift_nxt[0] : IDLE_LEVEL;
         r_frame_start <= w_shifting_nxt & (w_count_nxt == '0);
         r_frame_end   <= w_shifting_nxt & (w_count_nxt == c_last_idx);
         r_busy        <= w_shifting_nxt | w_hold_full_nxt;
      end
   end

   assign sif.in_ready    = ~r_hold_full;
   assign sif.ser_out     = r_ser_out;
   assign sif.ser_valid   = r_ser_valid;
   assign sif.frame_start = r_frame_start;
   assign sif.frame_end   = r_frame_end;
   assign sif.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_bit_serializer
// Purpose  : Random and directed bench for seq_bit_serializer (LSB- and
//            MSB-first instances) against a word/index reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_bit_serializer;

   localparam int WIDTH = 12;
`ifdef SER_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] din = '0;
   logic             vin = 1'b0;
   logic             sen = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_bit_serializer_if #(.WIDTH(WIDTH)) sif0 ();
   seq_bit_serializer_if #(.WIDTH(WIDTH)) sif1 ();

   assign sif0.in_data  = din;
   assign sif0.in_valid = vin;
   assign sif0.ser_en   = sen;
   assign sif1.in_data  = din;
   assign sif1.in_valid = vin;
   assign sif1.ser_en   = sen;

   seq_bit_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_lsb (
      .clk (clk),
      .rst (rst),
      .sif (sif0)
   );

   seq_bit_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_msb (
      .clk (clk),
      .rst (rst),
      .sif (sif1)
   );

   // Reference model: current frame word + bit position, one buffered word
   bit               m_active = 1'b0;
   int               m_idx    = 0;
   logic [WIDTH-1:0] m_word   = '0;
   bit               m_hold_v = 1'b0;
   logic [WIDTH-1:0] m_hold_w = '0;
   int               m_acc    = 0;

   function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int idx, input bit lsb);
      if (idx >= WIDTH) return ^w;
      return lsb ? w[idx] : w[WIDTH-1-idx];
   endfunction

   // {in_ready, busy, frame_end, frame_start, ser_out, ser_valid}
   function automatic logic [5:0] exp_vec(input bit lsb, input logic idle);
      logic o;
      o = m_active ? exp_bit(m_word, m_idx, lsb) : idle;
      return {~m_hold_v, m_active | m_hold_v, m_active && (m_idx == FLEN-1),
              m_active && (m_idx == 0), o, m_active};
   endfunction

   function automatic logic [5:0] got0();
      return {sif0.in_ready, sif0.busy, sif0.frame_end, sif0.frame_start, sif0.ser_out, sif0.ser_valid};
   endfunction

   function automatic logic [5:0] got1();
      return {sif1.in_ready, sif1.busy, sif1.frame_end, sif1.frame_start, sif1.ser_out, sif1.ser_valid};
   endfunction

   task automatic model_edge();
      bit had;
      if (rst) begin
         m_active = 1'b0;
         m_idx    = 0;
         m_hold_v = 1'b0;
         return;
      end
      had = m_hold_v;
      if (m_active && sen) begin
         if (m_idx == FLEN-1) m_active = 1'b0;
         else                 m_idx++;
      end
      if (!m_active && had) begin
         m_active = 1'b1;
         m_idx    = 0;
         m_word   = m_hold_w;
         m_hold_v = 1'b0;
      end
      if (!had && vin) begin
         m_hold_v = 1'b1;
         m_hold_w = din;
         m_acc++;
      end
   endtask

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("lsb_cyc", 16'(got0()), 16'(exp_vec(1'b1, 1'b0)));
      check_eq("msb_cyc", 16'(got1()), 16'(exp_vec(1'b0, 1'b1)));
   endtask

   // Sends one word from idle with ser_en=1 and records what comes out
   task automatic run_frame(input logic [WIDTH-1:0] w, output logic [FLEN-1:0] cap,
                            output int nv, output int lat, output logic [3:0] f4);
      int cyc;
      cap = '0; nv = 0; lat = 0; f4 = '0;
      din = w; vin = 1'b1; sen = 1'b1;
      step();
      cyc = 1;
      vin = 1'b0;
      din = WIDTH'($urandom);
      for (int k = 0; k < 60; k++) begin
         step();
         cyc++;
         if (sif0.ser_valid) begin
            if (nv == 0) lat = cyc;
            if (nv < FLEN) cap[nv] = sif0.ser_out;
            if (nv < 4) f4 = {f4[2:0], sif1.ser_out};
            nv++;
         end else if (nv > 0) begin
            break;
         end
      end
   endtask

   initial begin
      logic [FLEN-1:0] cap;
      logic [3:0]      f4;
      logic [WIDTH-1:0] w0;
      int nv, lat, run, ns, acc0, stalls;

      // Reset with in_valid high: nothing may be accepted
      rst = 1'b1; vin = 1'b1; din = 12'h5A5; sen = 1'b1;
      step();
      step();
      check_eq("rst_state", 16'(got0()), 16'(6'b100000));
      check_eq("rst_state_msb", 16'(got1()), 16'(6'b100010));
      rst = 1'b0; vin = 1'b0;
      step();
      check_eq("post_rst_idle", 16'(got0()), 16'(6'b100000));

      // Single word
      w0 = 12'b100101101111;
      run_frame(w0, cap, nv, lat, f4);
      check_eq("single_bits", 16'(cap[WIDTH-1:0]), 16'(w0));
      check_eq("single_len", 16'(nv), 16'(FLEN));
      check_eq("single_lat", 16'(lat), 16'd2);
      check_eq("msb_first4", 16'(f4), 16'(4'b1001));
      check_eq("single_idle", 16'(got0()), 16'(6'b100000));

      // Back-to-back with in_valid held high
      acc0 = m_acc; din = 12'hA5C; vin = 1'b1; sen = 1'b1; run = 0; ns = 0;
      for (int k = 0; k < 80; k++) begin
         step();
         if (m_acc == acc0 + 1) din = 12'h3F0;
         if (m_acc >= acc0 + 2) vin = 1'b0;
         ns += int'(sif0.frame_start);
         if (sif0.ser_valid) run++;
         else if (run > 0) break;
      end
      vin = 1'b0;
      check_eq("b2b_run", 16'(run), 16'(2*FLEN));
      check_eq("b2b_starts", 16'(ns), 16'd2);

      // Three-cycle stall on bit 5
      din = 12'b100101101111; vin = 1'b1; sen = 1'b1; stalls = 0; run = 0;
      step();
      vin = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (m_active && m_idx == 4 && stalls < 3) begin
            sen = 1'b0;
            stalls++;
         end else begin
            sen = 1'b1;
         end
         step();
         if (sif0.ser_valid) run++;
         else if (run > 0) break;
      end
      check_eq("stall_len", 16'(run), 16'(FLEN + 3));

      // Reset mid-frame with a second word buffered
      din = 12'h123; vin = 1'b1; sen = 1'b1;
      step();
      din = 12'h456;
      for (int k = 0; k < 40; k++) begin
         if (m_active && m_idx == 6) break;
         step();
         if (m_acc >= 2 && !m_hold_v && !m_active) vin = 1'b0;
      end
      vin = 1'b0;
      check_eq("midrst_buffered", 16'({m_hold_v, m_active}), 16'(2'b11));
      rst = 1'b1;
      step();
      check_eq("midrst_out", 16'({sif0.busy, sif0.ser_valid}), 16'd0);
      rst = 1'b0; run = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         run += int'(sif0.ser_valid | sif1.ser_valid);
      end
      check_eq("midrst_silent", 16'(run), 16'd0);

`ifdef SER_PARITY_EN
      run_frame(12'h001, cap, nv, lat, f4);
      check_eq("par_001", 16'({cap[FLEN-1], 5'(nv)}), 16'({1'b1, 5'd13}));
      run_frame(12'h003, cap, nv, lat, f4);
      check_eq("par_003", 16'({cap[FLEN-1], 5'(nv)}), 16'({1'b0, 5'd13}));
`endif

      // Random traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         din = WIDTH'($urandom);
         vin = 1'($urandom_range(0, 1));
         sen = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the serial-input Mealy sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per advance cycle on ser_out; ser_out drives the detector's inp.
- Adds frame markers and a downstream advance enable so the detector's stimulus is produced in hardware instead of a bench loop.
- A one-word holding buffer allows back-to-back frames with no idle bit between them.

Parameters:
- WIDTH, 12, data bits per frame; must be at least 2.
- LSB_FIRST, 1: 1 means bit 0 is sent first; 0 means bit WIDTH-1 is sent first.
- IDLE_LEVEL, 1'b0, level driven on ser_out when ser_valid is 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding buffer can accept a word.
- ser_en  input  1  downstream consumes the current bit at this edge.
- ser_out  output  1  current serial bit; connects to the detector's inp.
- ser_valid  output  1  ser_out carries a frame bit.
- frame_start  output  1  current bit is the first bit of a frame.
- frame_end  output  1  current bit is the last bit of a frame.
- busy  output  1  a frame is in flight or a word is buffered.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State returns to IDLE; holding buffer and shift register are emptied.
  - Bit counter is cleared to 0.
  - Outputs: ser_valid=0, ser_out=IDLE_LEVEL, frame_start=0, frame_end=0, busy=0.
  - in_ready=1 from the first cycle after reset.
  - A frame in progress or a buffered word is discarded and never resumed.
- in_ready = ~hold_full (combinational).
  - A word is accepted at an edge where in_valid & in_ready.
  - At that edge hold_full is set and in_data is captured.
- States:
  - IDLE: ser_valid=0. Transitions to SHIFT at the next edge if hold_full. That edge moves the hold word into the shift register, clears hold_full and zeroes the counter.
  - SHIFT: ser_valid=1. ser_out = shift-register bit selected by LSB_FIRST.
- Latency: a handshake at edge N puts the first bit on ser_out with ser_valid=1 after edge N+1, i.e. 2 cycles.
- Advance, at an edge with ser_valid & ser_en:
  - Not the last bit: shift by one and increment the counter.
  - Last bit (count==WIDTH-1):
    - If hold_full, load the next word at the same edge, clear hold_full and zero the counter. SHIFT is held, so there is no gap.
    - Otherwise go to IDLE, ser_valid=0.
- Stall: with ser_en=0, ser_out, the counter and the state hold unchanged. The holding buffer can still accept a word.
- Same-edge events: a hold-to-shift transfer and a new accept never occur at the same edge, because in_ready was 0 in that cycle. The buffer refills one cycle later, which is within the WIDTH>=2 frame time.
- frame_start = ser_valid & (count==0).
- frame_end = ser_valid & (count==last index).
- busy = ser_valid | hold_full.
- Counter width is $clog2(WIDTH+2). The counter never exceeds the last index.
- in_data is sampled only at the accept edge; later changes to in_data have no effect.

Optional Feature:
- SER_PARITY_EN defined:
  - After the WIDTH data bits, one even-parity bit (XOR of the word) is sent. Frame length is WIDTH+1 and the last index is WIDTH.
  - frame_end is asserted on the parity bit only.
  - The parity bit obeys ser_en stalls like any data bit.
  - The parity bit is computed at shift-register load.
- SER_PARITY_EN undefined: frames are exactly WIDTH bits and there is no parity logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> ser_valid=0, ser_out=0, busy=0, in_ready=1; no word is accepted during reset.
- Single word: 12'b100101101111, LSB_FIRST=1, ser_en=1 ->
  - ser_out sequence 1,1,1,1,0,1,1,0,1,0,0,1;
  - first bit 2 cycles after the handshake;
  - frame_start on bit 1 only, frame_end on bit 12 only;
  - IDLE and ser_valid=0 afterwards.
- Back-to-back: 12'hA5C then 12'h3F0 with in_valid held high ->
  - 24 consecutive ser_valid cycles, no gap;
  - second frame_start in the cycle after the first frame_end;
  - in_ready=0 while the buffer is full.
- Stall: ser_en=0 for 3 cycles while bit 5 is presented -> ser_out is held 4 cycles and the frame takes 15 cycles. With LSB_FIRST=0 on 12'b100101101111, the bit order is reversed, starting 1,0,0,1.
- Reset mid-frame: assert rst after 6 bits, with a second word buffered -> ser_valid=0 and busy=0 the next cycle. No further bits from either word are sent.
- SER_PARITY_EN: word 12'h001 -> 13 bits, 13th bit =1, frame_end on bit 13. Word 12'h003 -> 13th bit =0.
